// File: rtl/qpsk_tx_iq_shaper.sv
// Dual-channel (I/Q) polyphase upsampling pulse shaper with symbol handshake and saturating output.
// Optional macro QPSK_TX_ROUND_EN: round half up before saturation instead of truncating.
module qpsk_tx_iq_shaper #(
  parameter int unsigned UPSAMPLE    = 4,
  parameter int unsigned NCOEF       = 24,
  parameter int unsigned COEF_NBITS  = 8,
  parameter int unsigned COEF_NFBITS = 7,
  parameter int unsigned OUT_NBITS   = 8,
  parameter int unsigned OUT_NFBITS  = 7,
  parameter logic [NCOEF*COEF_NBITS-1:0] COEF = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 sym_valid_i,
  output logic                 sym_ready_o,
  input  logic                 sym_i_i,
  input  logic                 sym_q_i,
  output logic                 out_valid_o,
  output logic [OUT_NBITS-1:0] out_i_o,
  output logic [OUT_NBITS-1:0] out_q_o,
  output logic                 underflow_o
);

  localparam int unsigned NTAPS = NCOEF / UPSAMPLE;
  localparam int unsigned PW    = $clog2(UPSAMPLE);
  localparam int unsigned CW    = $clog2(NCOEF);
  localparam int unsigned SHIFT = COEF_NFBITS - OUT_NFBITS;
`ifdef QPSK_TX_ROUND_EN
  localparam int unsigned AW    = COEF_NBITS + $clog2(NTAPS) + 2;
  localparam int          RND   = (2 ** SHIFT) / 2;
`else
  localparam int unsigned AW    = COEF_NBITS + $clog2(NTAPS) + 1;
  localparam int          RND   = 0;
`endif
  localparam int unsigned SW    = (AW > OUT_NBITS) ? AW : OUT_NBITS;
  localparam logic signed [SW-1:0] MaxV = SW'((2 ** (OUT_NBITS - 1)) - 1);
  localparam logic signed [SW-1:0] MinV = ~MaxV;

  logic signed [COEF_NBITS-1:0] coef [NCOEF];

  for (genvar j = 0; j < NCOEF; j++) begin : g_coef
    assign coef[j] = COEF[(NCOEF-1-j)*COEF_NBITS +: COEF_NBITS];
  end

  logic [PW-1:0]        phase_q, phase_d;
  logic [NTAPS-1:0]     occ_q, occ_d, si_q, si_d, sq_q, sq_d;
  logic [OUT_NBITS-1:0] oi_q, oi_d, oq_q, oq_d;
  logic                 valid_q, valid_d, uf_q, uf_d;
  logic                 xfer;
  logic signed [AW-1:0] acc_i, acc_q, cext;
  logic [CW-1:0]        idx;

  function automatic logic [OUT_NBITS-1:0] scale_sat(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] s;
    logic signed [SW-1:0] w;
    s = (acc + AW'(RND)) >>> SHIFT;
    w = SW'(s);
    if (w > MaxV) return MaxV[OUT_NBITS-1:0];
    if (w < MinV) return MinV[OUT_NBITS-1:0];
    return w[OUT_NBITS-1:0];
  endfunction

  always_comb begin
    sym_ready_o = en_i & (phase_q == '0) & ~rst_i;
    xfer        = sym_ready_o & sym_valid_i;
    phase_d     = phase_q;
    occ_d       = occ_q;
    si_d        = si_q;
    sq_d        = sq_q;
    uf_d        = 1'b0;
    if (en_i) begin
      phase_d = (phase_q == PW'(UPSAMPLE - 1)) ? '0 : phase_q + PW'(1);
      if (phase_q == '0) begin
        // Slot 0 sign is don't-care when unoccupied, so the raw bits are loaded regardless.
        occ_d = (occ_q << 1) | NTAPS'(xfer);
        si_d  = (si_q << 1) | NTAPS'(sym_i_i);
        sq_d  = (sq_q << 1) | NTAPS'(sym_q_i);
        uf_d  = ~sym_valid_i;
      end
    end
  end

  // The sample produced at an edge uses the phase in force at that edge, so an accepted
  // symbol shows up as its coef[0] term in the very next output sample.
  always_comb begin
    acc_i = '0;
    acc_q = '0;
    cext  = '0;
    idx   = '0;
    for (int k = 0; k < int'(NTAPS); k++) begin
      idx  = CW'(k * int'(UPSAMPLE) + int'(phase_q));
      cext = {{(AW - COEF_NBITS){coef[idx][COEF_NBITS-1]}}, coef[idx]};
      if (occ_d[k]) begin
        acc_i = si_d[k] ? acc_i + cext : acc_i - cext;
        acc_q = sq_d[k] ? acc_q + cext : acc_q - cext;
      end
    end
    oi_d    = oi_q;
    oq_d    = oq_q;
    valid_d = 1'b0;
    if (en_i) begin
      oi_d    = scale_sat(acc_i);
      oq_d    = scale_sat(acc_q);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      occ_q   <= '0;
      si_q    <= '0;
      sq_q    <= '0;
      oi_q    <= '0;
      oq_q    <= '0;
      valid_q <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      occ_q   <= occ_d;
      si_q    <= si_d;
      sq_q    <= sq_d;
      oi_q    <= oi_d;
      oq_q    <= oq_d;
      valid_q <= valid_d;
      uf_q    <= uf_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_i_o     = oi_q;
  assign out_q_o     = oq_q;
  assign underflow_o = uf_q;

endmodule

// File: tb/tb_qpsk_tx_iq_shaper.sv
// Directed self-checking bench: three shaper configurations driven by one shared stimulus.
module tb_qpsk_tx_iq_shaper;

  localparam logic [31:0] COEF_A = {8'd10, 8'd20, 8'd30, 8'd40};
  localparam logic [63:0] COEF_B = {8{8'd100}};
  localparam logic [31:0] COEF_C = {8'd6, 24'd0};
`ifdef QPSK_TX_ROUND_EN
  localparam int RPOS = 2;
  localparam int RNEG = -1;
`else
  localparam int RPOS = 1;
  localparam int RNEG = -2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b1, sym_valid = 1'b0, si = 1'b0, sq = 1'b0;
  logic a_ready, a_valid, a_uf, b_ready, b_valid, b_uf, c_ready, c_valid, c_uf;
  logic signed [7:0] a_oi, a_oq, b_oi, b_oq, c_oi, c_oq;
  int n_cmp = 0;
  int n_fail = 0;
  int ca [4] = '{10, 20, 30, 40};

  always #5 clk = ~clk;

  qpsk_tx_iq_shaper #(.UPSAMPLE(4), .NCOEF(4), .COEF_NBITS(8), .COEF_NFBITS(7), .OUT_NBITS(8),
    .OUT_NFBITS(7), .COEF(COEF_A)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sym_valid_i(sym_valid), .sym_ready_o(a_ready),
    .sym_i_i(si), .sym_q_i(sq), .out_valid_o(a_valid), .out_i_o(a_oi), .out_q_o(a_oq),
    .underflow_o(a_uf));

  qpsk_tx_iq_shaper #(.UPSAMPLE(4), .NCOEF(8), .COEF_NBITS(8), .COEF_NFBITS(7), .OUT_NBITS(8),
    .OUT_NFBITS(7), .COEF(COEF_B)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sym_valid_i(sym_valid), .sym_ready_o(b_ready),
    .sym_i_i(si), .sym_q_i(sq), .out_valid_o(b_valid), .out_i_o(b_oi), .out_q_o(b_oq),
    .underflow_o(b_uf));

  qpsk_tx_iq_shaper #(.UPSAMPLE(4), .NCOEF(4), .COEF_NBITS(8), .COEF_NFBITS(7), .OUT_NBITS(8),
    .OUT_NFBITS(5), .COEF(COEF_C)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sym_valid_i(sym_valid), .sym_ready_o(c_ready),
    .sym_i_i(si), .sym_q_i(sq), .out_valid_o(c_valid), .out_i_o(c_oi), .out_q_o(c_oq),
    .underflow_o(c_uf));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b1; sym_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; sym_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", a_valid); end
    n_cmp++; if (a_oi !== 8'sd0) begin n_fail++; $display("FAIL reset out_i: got %0d want 0", a_oi); end
    n_cmp++; if (a_oq !== 8'sd0) begin n_fail++; $display("FAIL reset out_q: got %0d want 0", a_oq); end
    n_cmp++; if (a_uf !== 1'b0) begin n_fail++; $display("FAIL reset underflow: got %b want 0", a_uf); end
    n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %b want 0", a_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL release ready: got %b want 1", a_ready); end
  endtask

  task automatic test_stream;
    sym_valid = 1'b1; si = 1'b1; sq = 1'b0;
    for (int n = 0; n < 12; n++) begin
      n_cmp++;
      if (a_ready !== ((n % 4) == 0)) begin
        n_fail++; $display("FAIL stream ready[%0d]: got %b want %b", n, a_ready, (n % 4) == 0);
      end
      tick();
      n_cmp++;
      if (a_oi !== ca[n % 4] || a_oq !== -ca[n % 4] || a_valid !== 1'b1 || a_uf !== 1'b0) begin
        n_fail++;
        $display("FAIL stream[%0d]: got i=%0d q=%0d v=%b uf=%b want i=%0d q=%0d v=1 uf=0", n,
                 a_oi, a_oq, a_valid, a_uf, ca[n % 4], -ca[n % 4]);
      end
    end
  endtask

  task automatic test_underflow;
    int ei;
    sym_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (n == 4) sym_valid = 1'b1;
      tick();
      ei = (n < 4) ? 0 : ca[n - 4];
      n_cmp++;
      if (a_oi !== ei || a_oq !== -ei || a_uf !== (n == 0)) begin
        n_fail++;
        $display("FAIL underflow[%0d]: got i=%0d q=%0d uf=%b want i=%0d q=%0d uf=%b", n, a_oi,
                 a_oq, a_uf, ei, -ei, n == 0);
      end
    end
  endtask

  task automatic test_saturation;
    int ei, eq;
    do_reset();
    sym_valid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      si = (n < 8); sq = (n >= 8);
      tick();
      case (n / 4)
        0:       begin ei = 100;  eq = -100; end
        1:       begin ei = 127;  eq = -128; end
        2:       begin ei = 0;    eq = 0;    end
        default: begin ei = -128; eq = 127;  end
      endcase
      n_cmp++;
      if (b_oi !== ei || b_oq !== eq) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got i=%0d q=%0d want i=%0d q=%0d", n, b_oi, b_oq, ei, eq);
      end
    end
  endtask

  task automatic test_round;
    do_reset();
    sym_valid = 1'b1; si = 1'b1; sq = 1'b0;
    tick();
    n_cmp++;
    if (c_oi !== RPOS || c_oq !== RNEG) begin
      n_fail++;
      $display("FAIL scale: got i=%0d q=%0d want i=%0d q=%0d", c_oi, c_oq, RPOS, RNEG);
    end
    sym_valid = 1'b0;
    for (int n = 1; n < 4; n++) begin
      tick();
      n_cmp++;
      if (c_oi !== 8'sd0 || c_oq !== 8'sd0) begin
        n_fail++; $display("FAIL scale tail[%0d]: got i=%0d q=%0d want 0 0", n, c_oi, c_oq);
      end
    end
  endtask

  task automatic test_enable;
    int seq [4] = '{30, 40, 10, 20};
    do_reset();
    sym_valid = 1'b1; si = 1'b1; sq = 1'b0;
    tick(); tick();
    en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL freeze ready[%0d]: got %b want 0", n, a_ready); end
      tick();
      n_cmp++;
      if (a_valid !== 1'b0 || a_oi !== 8'sd20 || a_oq !== -8'sd20) begin
        n_fail++;
        $display("FAIL freeze[%0d]: got v=%b i=%0d q=%0d want v=0 i=20 q=-20", n, a_valid, a_oi, a_oq);
      end
    end
    en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      n_cmp++;
      if (a_ready !== (n == 2)) begin
        n_fail++; $display("FAIL resume ready[%0d]: got %b want %b", n, a_ready, n == 2);
      end
      tick();
      n_cmp++;
      if (a_valid !== 1'b1 || a_oi !== seq[n] || a_oq !== -seq[n] || a_uf !== 1'b0) begin
        n_fail++;
        $display("FAIL resume[%0d]: got v=%b i=%0d q=%0d uf=%b want v=1 i=%0d q=%0d uf=0", n,
                 a_valid, a_oi, a_oq, a_uf, seq[n], -seq[n]);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    sym_valid = 1'b1; si = 1'b1; sq = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL midrst ready: got %b want 0", a_ready); end
    tick();
    n_cmp++;
    if (a_valid !== 1'b0 || a_oi !== 8'sd0 || a_uf !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst: got v=%b i=%0d uf=%b want v=0 i=0 uf=0", a_valid, a_oi, a_uf);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (a_valid !== 1'b1 || a_oi !== 8'sd10 || a_uf !== 1'b0) begin
      n_fail++;
      $display("FAIL postrst: got v=%b i=%0d uf=%b want v=1 i=10 uf=0", a_valid, a_oi, a_uf);
    end
    n_cmp++;
    if (b_oi !== 8'sd100) begin n_fail++; $display("FAIL postrst flush: got %0d want 100", b_oi); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underflow();
    test_saturation();
    test_round();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
